// File: rtl/seq_pkg.sv
// Shared opcodes, FSM state encoding and instruction field positions for the sequencer.
package seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_JZ   = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalted
  } state_e;

  // Instruction word field positions
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned DST_MSB  = 11;
  localparam int unsigned DST_LSB  = 10;
  localparam int unsigned SRCA_MSB = 9;
  localparam int unsigned SRCA_LSB = 8;
  localparam int unsigned SRCB_MSB = 7;
  localparam int unsigned SRCB_LSB = 6;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned FN_MSB   = 2;
  localparam int unsigned FN_LSB   = 0;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: opcode class flags plus raw field extraction.
module seq_decode
  import seq_pkg::*;
(
  input  logic [15:0] ir,
  input  logic        z,
  output logic        is_ldi,
  output logic        is_alu,
  output logic        is_jump,
  output logic        is_halt,
  output logic [1:0]  dst,
  output logic [1:0]  srca,
  output logic [1:0]  srcb,
  output logic [7:0]  imm,
  output logic [2:0]  fn
);

  assign dst  = ir[DST_MSB:DST_LSB];
  assign srca = ir[SRCA_MSB:SRCA_LSB];
  assign srcb = ir[SRCB_MSB:SRCB_LSB];
  assign imm  = ir[IMM_MSB:IMM_LSB];
  assign fn   = ir[FN_MSB:FN_LSB];

  // Classify opcode; is_jump already folds in the JZ condition so the FSM sees a taken jump.
  always_comb begin
    is_ldi  = 1'b0;
    is_alu  = 1'b0;
    is_jump = 1'b0;
    is_halt = 1'b0;
    case (ir[OPC_MSB:OPC_LSB])
      OP_NOP:  ;
      OP_LDI:  is_ldi  = 1'b1;
      OP_ALU:  is_alu  = 1'b1;
      OP_JMP:  is_jump = 1'b1;
      OP_JZ:   is_jump = z;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches from a synchronous ROM and drives a 4x8 register file.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [15:0]     rom_data,
  input  logic [7:0]      alu_result,
  input  logic            alu_zero,
  output logic [2:0]      alu_op,
  output logic [7:0]      D,
  output logic [1:0]      addr,
  output logic            WE,
  output logic [1:0]      cha,
  output logic [1:0]      chb,
  output logic            busy,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            z_q, z_d;
  logic [1:0]      cha_q, cha_d, chb_q, chb_d;

  logic       is_ldi, is_alu, is_jump, is_halt;
  logic [1:0] dst, srca, srcb;
  logic [7:0] imm;
  logic [2:0] fn;

  seq_decode u_decode (
    .ir      (ir_q),
    .z       (z_q),
    .is_ldi  (is_ldi),
    .is_alu  (is_alu),
    .is_jump (is_jump),
    .is_halt (is_halt),
    .dst     (dst),
    .srca    (srca),
    .srcb    (srcb),
    .imm     (imm),
    .fn      (fn)
  );

  // pc is stable from FETCH through DECODE, so it can drive the ROM address directly.
  assign rom_addr = pc_q;
  assign alu_op   = fn;
  assign busy     = (state_q != StIdle) && (state_q != StHalted);
  assign halted   = (state_q == StHalted);

  // Next-state, architectural updates and register-file port drive.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    cha_d   = cha_q;
    chb_d   = chb_q;
    cha     = cha_q;
    chb     = chb_q;
    WE      = 1'b0;
    D       = 8'h00;
    addr    = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        ir_d    = rom_data;
        state_d = StExec;
      end
      StExec: begin
        if (is_alu) begin
          // Selects must be valid now; the register file samples them on this edge.
          cha     = srca;
          chb     = srcb;
          cha_d   = srca;
          chb_d   = srcb;
          state_d = StWb;
        end else if (is_halt) begin
          state_d = StHalted;
        end else begin
          if (is_ldi) begin
            WE   = 1'b1;
            D    = imm;
            addr = dst;
          end
          pc_d    = is_jump ? PC_W'(imm) : pc_q + PC_W'(1);
          state_d = StFetch;
        end
      end
      StWb: begin
        WE      = 1'b1;
        D       = alu_result;
        addr    = dst;
        z_d     = alu_zero;
        pc_d    = pc_q + PC_W'(1);
        state_d = StFetch;
      end
      StHalted: begin
        if (run) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= 16'h0000;
      z_q     <= 1'b0;
      cha_q   <= 2'd0;
      chb_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      cha_q   <= cha_d;
      chb_q   <= chb_d;
    end
  end

endmodule
